shadow_capture_ring: RTL and testbench

Parametrised successor to the single-snapshot shadow capture block: it keeps a ring of the last DEPTH snapshots of a DFF_BITS-wide register bundle and freezes the ring a programmable number of captures after a trigger. On request it dumps the frozen history serially, then daisy-chains the dumps of CHAINS_IN upstream capture blocks onto one serial output. It sits at each instrumented hierarchy level, such as the multiplier top, between the local datapath taps and the parent level's chain input.

---
 rtl/shadow_capture_ring.sv | 154 +++++++++++++++
 tb/tb_shadow_capture_ring.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shadow_capture_ring.sv
// shadow_capture_ring: ring of the last DEPTH snapshots, frozen POST_TRIG captures after a trigger, dumped serially then daisy-chained with upstream dumps.
// Ports: sh_clk/sh_rst clock and sync active-high reset; capture_en/din snapshot input; trigger arms the freeze;
// dump_en requests a dump; chains_in* upstream serial data/valid/done; chain_dump_en per-upstream dump request;
// chains_out* merged serial dump data/valid/done; frozen high while the ring is held or being dumped.
module shadow_capture_ring #(
    parameter int DFF_BITS  = 32,
    parameter int DEPTH     = 4,
    parameter int POST_TRIG = 1,
    parameter int CHAINS_IN = 2
) (
    input  logic                 sh_clk,
    input  logic                 sh_rst,
    input  logic                 capture_en,
    input  logic                 trigger,
    input  logic [DFF_BITS-1:0]  din,
    input  logic                 dump_en,
    input  logic [CHAINS_IN-1:0] chains_in,
    input  logic [CHAINS_IN-1:0] chains_in_vld,
    input  logic [CHAINS_IN-1:0] chains_in_done,
    output logic [CHAINS_IN-1:0] chain_dump_en,
    output logic                 chains_out,
    output logic                 chains_out_vld,
    output logic                 chains_out_done,
    output logic                 frozen
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);
    localparam int BW = DFF_BITS > 1 ? $clog2(DFF_BITS) : 1;
    localparam int CW = CHAINS_IN > 1 ? $clog2(CHAINS_IN) : 1;
    typedef enum logic [2:0] {ARMED, POST, FROZEN, DUMP_LOC, DUMP_UP, DONE} state_t;
    state_t               state_q, state_d;
    logic [DFF_BITS-1:0]  ring_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]        fill_q, fill_d, rem_q, rem_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [CHAINS_IN-1:0] cde_d;
    logic                 out_d, vld_d, done_d, frozen_d, we, start;
    logic [PW-1:0]        oldest, cur_rd;
    logic [BW-1:0]        cur_bit;
    logic [FW-1:0]        cur_rem;
    assign oldest = int'(wr_ptr_q) >= int'(fill_q) ? PW'(int'(wr_ptr_q) - int'(fill_q))
                                                   : PW'(int'(wr_ptr_q) + DEPTH - int'(fill_q));
    assign start   = (state_q == ARMED || state_q == POST || state_q == FROZEN) && dump_en;
    // The dump cycle itself already emits the first bit, so the read cursor is seeded from the ring state.
    assign cur_rd  = start ? oldest : rd_ptr_q;
    assign cur_bit = start ? '0 : bit_q;
    assign cur_rem = start ? fill_q : rem_q;
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        post_cnt_d = post_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        bit_d      = bit_q;
        rem_d      = rem_q;
        ch_d       = ch_q;
        cde_d      = '0;
        out_d      = 1'b0;
        vld_d      = 1'b0;
        done_d     = 1'b0;
        we         = 1'b0;
        case (state_q)
            ARMED, POST: begin
                if (capture_en && !dump_en) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
                    fill_d   = fill_q == FW'(DEPTH) ? fill_q : fill_q + 1'b1;
                end
                if (state_q == ARMED && trigger) begin
                    state_d    = POST_TRIG == 0 ? FROZEN : POST;
                    post_cnt_d = PW'(POST_TRIG);
                end
                if (state_q == POST && capture_en && !dump_en) begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    state_d    = post_cnt_q == PW'(1) ? FROZEN : POST;
                end
            end
            DUMP_UP: begin
                out_d = chains_in[ch_q];
                vld_d = chains_in_vld[ch_q];
                if (chains_in_done[ch_q]) begin
                    if (ch_q == CW'(CHAINS_IN - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ch_d  = ch_q + 1'b1;
                        cde_d = CHAINS_IN'(1) << (ch_q + 1'b1);
                    end
                end
            end
            DONE: begin
                fill_d   = '0;
                wr_ptr_d = '0;
                state_d  = ARMED;
            end
            default: ;
        endcase
        if (start || state_q == DUMP_LOC) begin
            if (cur_rem == '0) begin
                state_d = DUMP_UP;
                ch_d    = '0;
                cde_d   = CHAINS_IN'(1);
            end else begin
                state_d  = DUMP_LOC;
                out_d    = ring_q[cur_rd][cur_bit];
                vld_d    = 1'b1;
                rd_ptr_d = cur_rd;
                bit_d    = cur_bit + 1'b1;
                rem_d    = cur_rem;
                if (cur_bit == BW'(DFF_BITS - 1)) begin
                    bit_d    = '0;
                    rd_ptr_d = cur_rd == PW'(DEPTH - 1) ? '0 : cur_rd + 1'b1;
                    rem_d    = cur_rem - 1'b1;
                end
            end
        end
        frozen_d = state_d == FROZEN || state_d == DUMP_LOC || state_d == DUMP_UP || state_d == DONE;
    end
    always_ff @(posedge sh_clk) begin
        if (sh_rst) begin
            state_q         <= ARMED;
            wr_ptr_q        <= '0;
            fill_q          <= '0;
            post_cnt_q      <= '0;
            rd_ptr_q        <= '0;
            bit_q           <= '0;
            rem_q           <= '0;
            ch_q            <= '0;
            chain_dump_en   <= '0;
            chains_out      <= 1'b0;
            chains_out_vld  <= 1'b0;
            chains_out_done <= 1'b0;
            frozen          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            fill_q          <= fill_d;
            post_cnt_q      <= post_cnt_d;
            rd_ptr_q        <= rd_ptr_d;
            bit_q           <= bit_d;
            rem_q           <= rem_d;
            ch_q            <= ch_d;
            chain_dump_en   <= cde_d;
            chains_out      <= out_d;
            chains_out_vld  <= vld_d;
            chains_out_done <= done_d;
            frozen          <= frozen_d;
        end
    end
    always_ff @(posedge sh_clk) begin
        if (we) ring_q[wr_ptr_q] <= din;
    end
endmodule

// File: tb/tb_shadow_capture_ring.sv
// tb_shadow_capture_ring: randomized scoreboard bench for shadow_capture_ring with a queue-based history model.
module tb_shadow_capture_ring;
    localparam int W = 8, D = 4, PT = 1, C = 2;
    logic sh_clk = 1'b0, sh_rst = 1'b1, capture_en = 1'b0, trigger = 1'b0, dump_en = 1'b0;
    logic [W-1:0] din = '0;
    logic [C-1:0] chains_in = '0, chains_in_vld = '0, chains_in_done = '0;
    logic [C-1:0] chain_dump_en;
    logic chains_out, chains_out_vld, chains_out_done, frozen;
    int total = 0, bad = 0, cyc = 0, done_seen = 0, exp_done = 0, mode = 0, pcnt = 0;
    bit exp_q[$];
    logic [W-1:0] hist[$];
    bit up0[$], up1[$];

    shadow_capture_ring #(.DFF_BITS(W), .DEPTH(D), .POST_TRIG(PT), .CHAINS_IN(C)) dut (
        .sh_clk(sh_clk), .sh_rst(sh_rst), .capture_en(capture_en), .trigger(trigger), .din(din),
        .dump_en(dump_en), .chains_in(chains_in), .chains_in_vld(chains_in_vld),
        .chains_in_done(chains_in_done), .chain_dump_en(chain_dump_en), .chains_out(chains_out),
        .chains_out_vld(chains_out_vld), .chains_out_done(chains_out_done), .frozen(frozen));

    always #5 sh_clk = ~sh_clk;
    always @(posedge sh_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge sh_clk) begin
        if (chains_out_vld === 1'b1) begin
            if (exp_q.size() == 0) chk("extra_bit", chains_out_vld, 0);
            else chk("stream_bit", chains_out, exp_q.pop_front());
        end
        if (chains_out_done === 1'b1) begin
            done_seen++;
            chk("done_after_all_bits", exp_q.size(), 0);
        end
    end

    task automatic tick();
        @(posedge sh_clk);
        #1;
    endtask

    task automatic noise(input int act);
        for (int i = 0; i < C; i++)
            if (i != act) begin
                chains_in[i]      = 1'($urandom);
                chains_in_vld[i]  = 1'($urandom);
                chains_in_done[i] = ($urandom % 4) == 0;
            end
    endtask

    task automatic step(input bit c, input bit t, input logic [W-1:0] d);
        capture_en = c; trigger = t; din = d; dump_en = 1'b0;
        if (mode != 2) begin
            if (c) begin
                hist.push_back(d);
                if (hist.size() > D) void'(hist.pop_front());
            end
            if (mode == 1 && c) begin
                pcnt--;
                if (pcnt == 0) mode = 2;
            end else if (mode == 0 && t) begin
                if (PT == 0) mode = 2;
                else begin mode = 1; pcnt = PT; end
            end
        end
        tick();
        chk("frozen", frozen, mode == 2);
    endtask

    task automatic wait_cde(input int i, input int exp_cyc, input string nm);
        int n = 0;
        while (chain_dump_en[i] !== 1'b1 && n < 100) begin
            noise(-1);
            tick();
            n++;
        end
        chk(nm, cyc, exp_cyc);
        chk("cde_onehot", chain_dump_en, 1 << i);
    endtask

    task automatic send(input int i, input bit pl[$], output int d);
        foreach (pl[j]) begin
            repeat ($urandom_range(0, 2)) begin
                noise(i); chains_in_vld[i] = 1'b0; chains_in_done[i] = 1'b0; tick();
            end
            noise(i); chains_in_vld[i] = 1'b1; chains_in[i] = pl[j]; chains_in_done[i] = 1'b0; tick();
        end
        noise(i); chains_in_vld[i] = 1'b0; chains_in_done[i] = 1'b1;
        d = cyc;
        tick();
        chains_in_done[i] = 1'b0;
    endtask

    task automatic rand_payload();
        up0.delete(); up1.delete();
        repeat ($urandom_range(0, 4)) up0.push_back(1'($urandom));
        repeat ($urandom_range(0, 4)) up1.push_back(1'($urandom));
    endtask

    task automatic dump(input bit abort);
        int t, f, d0, d1;
        f = hist.size();
        foreach (hist[k]) for (int b = 0; b < W; b++) exp_q.push_back(hist[k][b]);
        foreach (up0[k]) exp_q.push_back(up0[k]);
        foreach (up1[k]) exp_q.push_back(up1[k]);
        t = cyc;
        dump_en = 1'b1; capture_en = 1'b1; trigger = 1'($urandom); din = W'($urandom); noise(-1);
        tick();
        dump_en = 1'b0; capture_en = 1'($urandom); trigger = 1'($urandom);
        chk("frozen_at_t1", frozen, 1);
        if (f > 0) chk("first_bit_at_t1", chains_out_vld, 1);
        wait_cde(0, t + f * W + 1, "cde0_time");
        if (abort) begin
            capture_en = 1'b0; trigger = 1'b0;
            noise(0); chains_in_vld[0] = 1'b1; chains_in[0] = up0[0]; chains_in_done[0] = 1'b0;
            tick();
            sh_rst = 1'b1; chains_in_vld[0] = 1'b1;
            tick();
            sh_rst = 1'b0;
            chk("rst_outputs", {chain_dump_en, chains_out, chains_out_vld, chains_out_done, frozen}, 0);
            exp_q.delete(); hist.delete(); mode = 0; pcnt = 0;
            chains_in_done = '0;
            repeat (3) begin chains_in_vld[0] = 1'b1; chains_in[0] = 1'b1; tick(); end
            chains_in_done[0] = 1'b1; tick();
            chains_in_done = '0; chains_in_vld = '0;
            chk("after_rst_frozen", frozen, 0);
            return;
        end
        send(0, up0, d0);
        wait_cde(1, d0 + 1, "cde1_time");
        send(1, up1, d1);
        chk("out_done", chains_out_done, 1);
        exp_done++;
        capture_en = 1'b0; trigger = 1'b0; chains_in = '0; chains_in_vld = '0; chains_in_done = '0;
        tick();
        hist.delete(); mode = 0; pcnt = 0;
        chk("rearmed_frozen", frozen, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outputs", {chain_dump_en, chains_out, chains_out_vld, chains_out_done, frozen}, 0);
        sh_rst = 1'b0;
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, W'(i));
        up0 = '{1, 0, 1}; up1 = '{1, 1};
        dump(1'b0);
        step(1'b1, 1'b0, 8'hA0);
        step(1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 8'hA3);
        rand_payload();
        dump(1'b0);
        sh_rst = 1'b1; tick(); sh_rst = 1'b0;
        rand_payload();
        dump(1'b0);
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        up0 = '{1, 0, 1}; up1 = '{1};
        dump(1'b1);
        rand_payload();
        dump(1'b0);
        step(1'b1, 1'b1, 8'hB0);
        rand_payload();
        dump(1'b0);
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 9)) step(1'($urandom), ($urandom % 4) == 0, W'($urandom));
            rand_payload();
            dump(1'b0);
        end
        repeat (3) tick();
        chk("done_count", done_seen, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
